// File: rtl/counter_scheduler.sv
// counter_scheduler
//    Shares one external up-counter among NUM_REQ requesters. A round-robin
//    arbiter picks an owner. The counter is then loaded so that its overflow
//    fires after the requested number of enabled cycles, and the owner gets a
//    one-cycle done pulse when the interval completes. An abort cancels the
//    interval in progress. If abort and overflow arrive together, completion
//    takes priority.
//
// Ports
//    i_clk             system clock, rising edge
//    i_rst             synchronous active-high reset
//    i_req             per-requester interval request (level)
//    i_req_len         packed interval lengths, requester i at [i*WIDTH +: WIDTH]
//    i_abort           cancel the interval in LOAD/RUN
//    o_grant           one-hot owner, zero when idle
//    o_busy            state != IDLE
//    o_done            one-cycle completion pulse to the owner
//    o_aborted         one-cycle pulse when an interval is cancelled
//    o_ctr_load        counter load strobe
//    o_ctr_load_value  counter load value (0 outside LOAD)
//    o_ctr_en          counter enable
//    i_ctr_overflow    counter at CTR_MAX
//
// state | meaning
// IDLE  | waiting for a request, arbitrating round-robin from r_ptr
// LOAD  | counter loaded with CTR_MAX - len
// RUN   | counter enabled until overflow
// DONE  | done pulse to owner, pointer advances past owner

module counter_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int CTR_MAX = (1 << WIDTH) - 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_REQ-1:0]       i_req,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_len,
   input  logic                     i_abort,
   output logic [NUM_REQ-1:0]       o_grant,
   output logic                     o_busy,
   output logic [NUM_REQ-1:0]       o_done,
   output logic                     o_aborted,
   output logic                     o_ctr_load,
   output logic [WIDTH-1:0]         o_ctr_load_value,
   output logic                     o_ctr_en,
   input  logic                     i_ctr_overflow
);

   localparam int              IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(CTR_MAX);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [IW-1:0]    r_ptr;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_len;

   logic             w_any;
   logic [IW-1:0]    w_win;
   logic [WIDTH-1:0] w_win_len;
   logic [WIDTH-1:0] w_len_clamped;
   logic [IW:0]      w_sum;
   logic [IW-1:0]    w_cand;
   logic [NUM_REQ-1:0] w_onehot;

   function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
      if (idx == IW'(NUM_REQ - 1)) return '0;
      else                         return idx + IW'(1);
   endfunction

   // Scan offsets from the highest down so the candidate closest to r_ptr
   // is the last one written and therefore wins.
   always_comb begin
      w_any  = 1'b0;
      w_win  = r_ptr;
      w_sum  = '0;
      w_cand = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_ptr} + (IW + 1)'(k);
         if (w_sum >= (IW + 1)'(NUM_REQ)) w_sum = w_sum - (IW + 1)'(NUM_REQ);
         w_cand = w_sum[IW-1:0];
         if (i_req[w_cand]) begin
            w_any = 1'b1;
            w_win = w_cand;
         end
      end
      w_win_len     = i_req_len[w_win*WIDTH +: WIDTH];
      w_len_clamped = (w_win_len > MAXV) ? MAXV : w_win_len;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_len   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_idx   <= w_win;
                  r_len   <= w_len_clamped;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (i_abort) begin
                  r_state <= S_IDLE;
                  r_ptr   <= f_next(r_idx);
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (i_ctr_overflow) begin
                  r_state <= S_DONE;
               end else if (i_abort) begin
                  r_state <= S_IDLE;
                  r_ptr   <= f_next(r_idx);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ptr   <= f_next(r_idx);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_onehot = NUM_REQ'(1) << r_idx;

   assign o_busy           = (r_state != S_IDLE);
   assign o_grant          = o_busy ? w_onehot : '0;
   assign o_done           = (r_state == S_DONE) ? w_onehot : '0;
   // Reset cancels silently, and overflow in RUN beats a concurrent abort.
   assign o_aborted        = ~i_rst & i_abort &
                             ((r_state == S_LOAD) ||
                              ((r_state == S_RUN) && !i_ctr_overflow));
   assign o_ctr_load       = (r_state == S_LOAD);
   assign o_ctr_load_value = (r_state == S_LOAD) ? (MAXV - r_len) : '0;
   assign o_ctr_en         = (r_state == S_RUN) & ~i_ctr_overflow & ~i_abort;

endmodule

// File: tb/tb_counter_scheduler.sv
module tb_counter_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_len;
   logic           abort;
   logic [N-1:0]   grant, done;
   logic           busy, aborted, ctr_load, ctr_en, ctr_ovf;
   logic [W-1:0]   ctr_val;

   logic [N-1:0]   req_b;
   logic [N*W-1:0] req_len_b;
   logic [N-1:0]   grant_b, done_b;
   logic           busy_b, aborted_b, load_b, en_b, ovf_b;
   logic [W-1:0]   val_b;

   int checks = 0;
   int failures = 0;

   counter_scheduler #(.NUM_REQ(N), .WIDTH(W), .CTR_MAX(255)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_len(req_len), .i_abort(abort),
      .o_grant(grant), .o_busy(busy), .o_done(done), .o_aborted(aborted),
      .o_ctr_load(ctr_load), .o_ctr_load_value(ctr_val), .o_ctr_en(ctr_en),
      .i_ctr_overflow(ctr_ovf)
   );

   counter_scheduler #(.NUM_REQ(N), .WIDTH(W), .CTR_MAX(100)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_req_len(req_len_b), .i_abort(1'b0),
      .o_grant(grant_b), .o_busy(busy_b), .o_done(done_b), .o_aborted(aborted_b),
      .o_ctr_load(load_b), .o_ctr_load_value(val_b), .o_ctr_en(en_b),
      .i_ctr_overflow(ovf_b)
   );

   // Behavioural models of the shared up-counters
   logic [W-1:0] cnt_a = '0;
   logic [W-1:0] cnt_b = '0;
   always @(posedge clk) begin
      if (ctr_load)    cnt_a <= ctr_val;
      else if (ctr_en) cnt_a <= (cnt_a == 8'd255) ? 8'd0 : cnt_a + 8'd1;
      if (load_b)      cnt_b <= val_b;
      else if (en_b)   cnt_b <= (cnt_b == 8'd100) ? 8'd0 : cnt_b + 8'd1;
   end
   assign ctr_ovf = (cnt_a == 8'd255);
   assign ovf_b   = (cnt_b == 8'd100);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_len(input int i, input logic [W-1:0] v);
      req_len[i*W +: W] = v;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_grant"}, 32'(grant), 0);
      chk({tag, "_en"}, 32'(ctr_en), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_aborted"}, 32'(aborted), 0);
   endtask

   // Starts in an IDLE cycle where the request is visible; ends in the IDLE
   // cycle after DONE.
   task automatic run_iv(input string tag, input int exp_idx, input int len,
                         input int exp_val, input bit drop);
      logic [N-1:0] oh;
      oh = 4'b0001 << exp_idx;
      tick();
      chk({tag, "_ld_grant"}, 32'(grant), 32'(oh));
      chk({tag, "_ld"}, 32'(ctr_load), 1);
      chk({tag, "_ld_val"}, 32'(ctr_val), 32'(exp_val));
      chk({tag, "_ld_en"}, 32'(ctr_en), 0);
      for (int k = 1; k <= len; k++) begin
         tick();
         chk({tag, "_run_en"}, 32'(ctr_en), 1);
         chk({tag, "_run_ld"}, 32'(ctr_load), 0);
         chk({tag, "_run_val"}, 32'(ctr_val), 0);
         chk({tag, "_run_grant"}, 32'(grant), 32'(oh));
         if (drop && k == 2) req = '0;
      end
      tick();
      chk({tag, "_ovf_en"}, 32'(ctr_en), 0);
      chk({tag, "_ovf_done"}, 32'(done), 0);
      tick();
      chk({tag, "_done"}, 32'(done), 32'(oh));
      chk({tag, "_done_grant"}, 32'(grant), 32'(oh));
      tick();
      chk_idle({tag, "_end"});
   endtask

   initial begin
      int n_en;
      bit got;
      logic [N-1:0] done_seen;

      rst = 1'b1; req = '0; req_len = '0; abort = 1'b0;
      req_b = '0; req_len_b = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk_idle("reset");
      chk("reset_ldval", 32'(ctr_val), 0);
      chk("reset_ld", 32'(ctr_load), 0);
      chk("reset_b_busy", 32'(busy_b), 0);

      // Round-robin, all requesting, lengths 1..4
      set_len(0, 8'd1); set_len(1, 8'd2); set_len(2, 8'd3); set_len(3, 8'd4);
      req = 4'b1111;
      run_iv("rr0", 0, 1, 254, 0);
      run_iv("rr1", 1, 2, 253, 0);
      run_iv("rr2", 2, 3, 252, 0);
      run_iv("rr3", 3, 4, 251, 0);
      run_iv("rr0b", 0, 1, 254, 0);
      req = '0;

      // Single request, owner drops req mid-RUN
      set_len(1, 8'd5);
      req = 4'b0010;
      run_iv("single", 1, 5, 250, 1);
      req = '0;

      // Zero length
      set_len(3, 8'd0);
      req = 4'b1000;
      run_iv("zero", 3, 0, 255, 0);
      req = '0;

      // Abort mid-RUN
      set_len(0, 8'd10);
      req = 4'b0001;
      tick();
      chk("abt_ld_grant", 32'(grant), 32'h1);
      req = '0;
      tick(); tick();
      abort = 1'b1;
      #1;
      chk("abt_pulse", 32'(aborted), 1);
      chk("abt_en", 32'(ctr_en), 0);
      chk("abt_done", 32'(done), 0);
      tick();
      abort = 1'b0;
      #1;
      chk_idle("abt_after");
      set_len(1, 8'd2);
      req = 4'b0011;
      run_iv("abt_next", 1, 2, 253, 0);
      req = '0;

      // Abort coincident with overflow: completion wins
      set_len(2, 8'd3);
      req = 4'b0100;
      tick();
      req = '0;
      tick(); tick(); tick(); tick();
      abort = 1'b1;
      #1;
      chk("ao_ovf_aborted", 32'(aborted), 0);
      chk("ao_ovf_en", 32'(ctr_en), 0);
      chk("ao_ovf_busy", 32'(busy), 1);
      tick();
      chk("ao_done", 32'(done), 32'h4);
      chk("ao_done_aborted", 32'(aborted), 0);
      tick();
      chk_idle("ao_idle_abort");
      abort = 1'b0;

      // Reset mid-RUN
      set_len(2, 8'd20);
      req = 4'b0100;
      tick();
      chk("rst_ld_grant", 32'(grant), 32'h4);
      req = '0;
      tick(); tick();
      chk("rst_pre_en", 32'(ctr_en), 1);
      rst = 1'b1;
      #1;
      chk("rst_cyc_aborted", 32'(aborted), 0);
      tick();
      chk_idle("rst_1");
      tick();
      chk_idle("rst_2");
      rst = 1'b0;
      set_len(0, 8'd1);
      req = 4'b1001;
      run_iv("post_rst", 0, 1, 254, 0);
      req = '0;

      // Clamp on CTR_MAX=100 instance
      req_b = 4'b0001;
      req_len_b[7:0] = 8'd200;
      tick();
      chk("clamp_ld", 32'(load_b), 1);
      chk("clamp_val", 32'(val_b), 0);
      chk("clamp_grant", 32'(grant_b), 32'h1);
      req_b = '0;
      n_en = 0;
      got = 1'b0;
      done_seen = '0;
      for (int c = 0; c < 300 && !got; c++) begin
         tick();
         if (en_b) n_en++;
         if (done_b != '0) begin
            got = 1'b1;
            done_seen = done_b;
         end
      end
      chk("clamp_done_seen", 32'(got), 1);
      chk("clamp_done", 32'(done_seen), 32'h1);
      chk("clamp_en_cycles", 32'(n_en), 100);
      tick();
      chk("clamp_end_busy", 32'(busy_b), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
